seq_shift_add_multiplier: RTL and testbench

//  Parametrised sequential shift-add multiplier: a controller FSM and an integrated datapath.
//  - Accepts two WIDTH-bit operands on start; returns a 2*WIDTH-bit product with a valid flag.
//  - Processes one multiplier bit per cycle; optional early exit once the remaining multiplier is 0.
//  - Standalone arithmetic unit used by the team's datapath projects.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_fsm.sv | 69 ++++++
 rtl/seq_shift_add_multiplier.sv | 112 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and counter sizing. Signed operation is selected by the MULT_SIGNED_EN macro.
package mult_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_fsm.sv
// Controller for the shift-add multiplier: IDLE -> RUN -> DONE, one multiplier
// bit consumed per RUN cycle. Unused encoding 3 falls back to IDLE.
module mult_fsm
    import mult_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               b_zero,
    input  logic               cnt_done,
    output logic               load,
    output logic               step,
    output logic               finish,
    output logic               busy,
    output logic               valid,
    output logic [STATE_W-1:0] state
);

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                // Termination test takes precedence over another add/shift.
                if (cnt_done || b_zero) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DONE: begin
                valid = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign state = state_reg;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier datapath (A/B/P/cnt registers and adder).
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude inside).
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 valid,
    output logic                 busy,
    output logic [STATE_W-1:0]   out_state
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int PW    = 2 * WIDTH;

    logic [PW-1:0]    a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]    p_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [PW-1:0]    product_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    result;
    logic             load;
    logic             step;
    logic             finish;
    logic             b_zero;
    logic             cnt_done;

    assign b_zero   = EARLY_EXIT && (b_reg == '0);
    assign cnt_done = (cnt_reg == CNT_W'(WIDTH));

    // Partial product for this step: A gated by the current multiplier LSB.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_addend
            assign addend[gi] = a_reg[gi] & b_reg[0];
        end
    endgenerate

`ifdef MULT_SIGNED_EN
    logic neg_reg;

    // Most negative input maps to 2^(WIDTH-1), which fits as unsigned.
    assign a_mag  = a_in[WIDTH-1] ? (~a_in + WIDTH'(1)) : a_in;
    assign b_mag  = b_in[WIDTH-1] ? (~b_in + WIDTH'(1)) : b_in;
    assign result = neg_reg ? (~p_reg + PW'(1)) : p_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_reg <= 1'b0;
        end else if (load) begin
            neg_reg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
        end
    end
`else
    assign a_mag  = a_in;
    assign b_mag  = b_in;
    assign result = p_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            p_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            if (load) begin
                a_reg   <= {{WIDTH{1'b0}}, a_mag};
                b_reg   <= b_mag;
                p_reg   <= '0;
                cnt_reg <= '0;
            end else if (step) begin
                p_reg   <= p_reg + addend;
                a_reg   <= a_reg << 1;
                b_reg   <= b_reg >> 1;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (finish) begin
                product_reg <= result;
            end
        end
    end

    mult_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .b_zero   (b_zero),
        .cnt_done (cnt_done),
        .load     (load),
        .step     (step),
        .finish   (finish),
        .busy     (busy),
        .valid    (valid),
        .state    (out_state)
    );

    assign product = product_reg;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: early-exit and fixed-latency instances
// side by side, table vectors plus reset/restart sequences and random vectors.
module tb_seq_shift_add_multiplier;

    localparam int W       = 8;
    localparam int MAX_CYC = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;

    logic [2*W-1:0] prod_ee, prod_fx;
    logic           valid_ee, valid_fx, busy_ee, busy_fx;
    logic [1:0]     state_ee, state_fx;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .product(prod_ee), .valid(valid_ee), .busy(busy_ee), .out_state(state_ee)
    );

    seq_shift_add_multiplier #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_fx (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .product(prod_fx), .valid(valid_fx), .busy(busy_fx), .out_state(state_fx)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        int             lat_ee;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat_ee;
        int             lat_fx;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
`else
        logic [2*W-1:0] ua, ub;
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        return ua * ub;
`endif
    endfunction

    function automatic int model_lat(input logic [W-1:0] b);
        logic [W-1:0] mag;
        int k;
`ifdef MULT_SIGNED_EN
        mag = b[W-1] ? (~b + 1'b1) : b;
`else
        mag = b;
`endif
        if (mag == '0) return 2;
        k = 0;
        for (int i = 0; i < W; i++) if (mag[i]) k = i;
        return k + 3;
    endfunction

    // Drives one start, follows both instances until valid, then scores.
    // glitch_at > 0 injects a one-cycle start with junk operands mid-RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] ep, input int el,
                          input string tag, input int glitch_at);
        exp_t e;
        int cyc, lat_ee, lat_fx;
        bit done_ee, done_fx, busy_ok;
        sb_q.push_back('{prod: ep, lat_ee: el, lat_fx: W + 2});
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; done_ee = 0; done_fx = 0; busy_ok = 1; lat_ee = -1; lat_fx = -1;
        while (!(done_ee && done_fx) && cyc < MAX_CYC) begin
            if (!done_ee) begin
                if (valid_ee) begin done_ee = 1; lat_ee = cyc; end
                else if (!busy_ee) busy_ok = 0;
            end
            if (!done_fx) begin
                if (valid_fx) begin done_fx = 1; lat_fx = cyc; end
                else if (!busy_fx) busy_ok = 0;
            end
            if (glitch_at > 0 && cyc == glitch_at) begin
                start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
            end else begin
                start = 1'b0;
            end
            if (!(done_ee && done_fx)) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (!(done_ee && done_fx)) begin
            total_cnt++;
            $display("FAIL %s timeout: valid_ee=%0b valid_fx=%0b after %0d cycles, required both high",
                     tag, valid_ee, valid_fx, cyc);
        end
        e = sb_q.pop_front();
        check({tag, " prod_ee"}, 32'(prod_ee), 32'(e.prod));
        check({tag, " prod_fx"}, 32'(prod_fx), 32'(e.prod));
        check({tag, " lat_ee"}, lat_ee, e.lat_ee);
        check({tag, " lat_fx"}, lat_fx, e.lat_fx);
        check({tag, " busy_in_run"}, 32'(busy_ok), 32'd1);
        $display("op %s a=%0h b=%0h prod_ee=%0h prod_fx=%0h lat_ee=%0d lat_fx=%0d",
                 tag, a, b, prod_ee, prod_fx, lat_ee, lat_fx);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
`ifdef MULT_SIGNED_EN
        vecs[0] = '{a: 8'h80, b: 8'hFF, prod: 16'h0080, lat_ee: 3};
        vecs[1] = '{a: 8'hFB, b: 8'h07, prod: 16'hFFDD, lat_ee: 5};
        vecs[2] = '{a: 8'h80, b: 8'h80, prod: 16'h4000, lat_ee: 10};
        vecs[3] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143,  lat_ee: 6};
        vecs[4] = '{a: 8'hFF, b: 8'h00, prod: 16'h0000, lat_ee: 2};
        vecs[5] = '{a: 8'hFD, b: 8'hFC, prod: 16'd12,   lat_ee: 5};
        vecs[6] = '{a: 8'h00, b: 8'h80, prod: 16'h0000, lat_ee: 10};
        vecs[7] = '{a: 8'd7,   b: 8'd6,   prod: 16'd42,   lat_ee: 5};
`else
        vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143,   lat_ee: 6};
        vecs[1] = '{a: 8'd255, b: 8'd0,   prod: 16'd0,     lat_ee: 2};
        vecs[2] = '{a: 8'd255, b: 8'd255, prod: 16'd65025, lat_ee: 10};
        vecs[3] = '{a: 8'd3,   b: 8'd1,   prod: 16'd3,     lat_ee: 3};
        vecs[4] = '{a: 8'd3,   b: 8'd0,   prod: 16'd0,     lat_ee: 2};
        vecs[5] = '{a: 8'd7,   b: 8'd6,   prod: 16'd42,    lat_ee: 5};
        vecs[6] = '{a: 8'd1,   b: 8'd128, prod: 16'd128,   lat_ee: 10};
        vecs[7] = '{a: 8'd200, b: 8'd2,   prod: 16'd400,   lat_ee: 4};
`endif
        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'(state_ee), 32'd0);
        check("reset valid", 32'(valid_ee), 32'd0);
        check("reset busy", 32'(busy_ee), 32'd0);
        check("reset product", 32'(prod_ee), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat_ee, $sformatf("vec%0d", i), 0);

        // Result held in DONE while start stays low.
        repeat (5) @(posedge clk);
        #1;
        check("hold valid", 32'(valid_ee), 32'd1);
        check("hold product", 32'(prod_ee), 32'(vecs[7].prod));
        check("hold state", 32'(state_ee), 32'd2);

        // Start pulses during RUN must not disturb the running operation.
        run_op(8'd13, 8'd11, model_prod(8'd13, 8'd11), 6, "glitch2", 2);
        run_op(8'd13, 8'd11, model_prod(8'd13, 8'd11), 6, "glitch3", 3);
        // Restart straight from DONE.
        run_op(8'd7, 8'd6, model_prod(8'd7, 8'd6), 5, "restart", 0);

        // Reset mid-RUN aborts with no result.
        @(negedge clk);
        a_in = 8'd13; b_in = 8'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrun busy", 32'(busy_ee), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort state", 32'(state_ee), 32'd0);
        check("abort valid", 32'(valid_ee), 32'd0);
        check("abort busy", 32'(busy_ee), 32'd0);
        check("abort product", 32'(prod_ee), 32'd0);
        check("abort product_fx", 32'(prod_fx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(8'd13, 8'd11, model_prod(8'd13, 8'd11), 6, "after_reset", 0);

        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_op(ra, rb, model_prod(ra, rb), model_lat(rb), $sformatf("rnd%0d", n), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
